ctrl_pipe_seq: RTL and testbench
================================

// Module: ctrl_pipe_seq
// PURPOSE
// Main-control successor for the 5-stage RV32 core. Decodes the ID-stage opcode into a control bundle,
// carries the bundle through the ID/EX, EX/MEM and MEM/WB registers, and applies stall, flush and bubble rules.
// Adds a multi-cycle sequencer that holds a MUL-class R-type in EX for MC_LAT cycles.
// Sits between the ID decoder/hazard unit and the datapath pipeline registers.
// PARAMETERS
// OP_W     7  opcode width
// ALUOP_W  2  ALUOp field width
// MC_LAT   4  EX residency in cycles of a multi-cycle op (>=1; 1 = no stall)
// CNT_W    $clog2(MC_LAT+1)  sequencer counter width (derived, do not override)
// PORTS
// clk_i           in   1        clock, rising edge
// rst_i           in   1        async reset, active-low
// op_i            in   OP_W     ID-stage opcode
// funct7_i        in   7        ID-stage funct7; 7'b0000001 with R-type = multi-cycle op
// noop_i          in   1        hazard unit: inject bubble into ID/EX
// flush_i         in   1        branch taken: squash ID-stage instruction
// mem_stall_i     in   1        cache miss: freeze entire control pipeline
// alu_op_ex_o     out  ALUOP_W  EX ALUOp: 10 R, 11 I, 00 lw/sw, 01 beq
// alu_src_ex_o    out  1        EX operand-B select immediate
// branch_ex_o     out  1        EX branch
// mem_read_ex_o   out  1        EX load (for hazard detection)
// mem_read_mem_o  out  1        MEM load
// mem_write_mem_o out  1        MEM store
// reg_write_mem_o out  1        MEM regwrite (for forwarding)
// reg_write_wb_o  out  1        WB regwrite
// mem_to_reg_wb_o out  1        WB writeback select memory
// mc_stall_o      out  1        multi-cycle op busy: stall PC and IF/ID
// mc_done_o       out  1        one-cycle pulse in the final EX cycle of a multi-cycle op
// illegal_o       out  1        illegal opcode in ID (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_i=0, async): all stage registers are set to bubble (all zero), all outputs 0, FSM IDLE, cnt=0.
//   Reset mid-op discards any in-flight multi-cycle op.
// - Decode is combinational on op_i:
//   - R: RegWrite.
//   - I: RegWrite, ALUSrc.
//   - lw: RegWrite, MemtoReg, MemRead, ALUSrc.
//   - sw: MemWrite, ALUSrc.
//   - beq: Branch.
//   - Any other opcode: all-zero bundle.
//   - noop_i=1: all-zero bundle.
// - Stage outputs are registered: 1-cycle latency per stage; no combinational path from inputs to stage outputs.
// - Update priority each edge:
//   - mem_stall_i=1: all three registers and the FSM hold.
//   - else mc_stall_o=1: ID/EX holds; EX/MEM loads a bubble; MEM/WB advances.
//   - else flush_i=1: ID/EX loads a bubble.
//   - else: normal shift.
// - flush_i is ignored while mc_stall_o=1 (branch cannot be in EX then).
// - Sequencer, states IDLE / BUSY:
//   - mul_ex means the ID/EX bundle is R-type with the multi-cycle flag set; the flag is registered alongside the bundle.
//   - IDLE & mul_ex & MC_LAT>1: mc_stall_o=1 (Mealy); cnt<=1; go to BUSY.
//   - BUSY: mc_stall_o = (cnt != MC_LAT-1); cnt increments on each non-mem_stall edge.
//   - BUSY, cnt == MC_LAT-1: mc_stall_o=0 and mc_done_o=1; the op advances; return to IDLE with cnt=0.
//   - MC_LAT=1: FSM stays IDLE; mc_stall_o is never 1; mc_done_o pulses on mul_ex.
//   - mem_stall_i freezes cnt and state; mc_done_o is suppressed while mem_stall_i=1.
//   - Back-to-back multi-cycle ops: the second restarts from IDLE on the cycle after release.
//   - The counter never exceeds MC_LAT-1; no wrap-around.
// CONFIGURATION
// - Macro CTRL_ILLEGAL_TRAP_EN defined:
//   - An opcode outside {R, I, lw, sw, beq} with noop_i=0 drives illegal_o=1 combinationally in ID.
//   - Its bundle is forced to bubble.
// - Macro not defined: illegal_o is tied to 0; unknown opcodes decode to the all-zero bundle silently.
// STRUCTURE
// - Shared package ctrl_pkg holds:
//   - opcode constants (Rtype/Itype/lw/sw/beq);
//   - ALUOp encodings;
//   - MULDIV_FUNCT7;
//   - the ctrl_bundle_t struct {reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch, alu_op, is_mc};
//   - CTRL_BUBBLE constant.
// - One sub-module, ctrl_stage_reg: a bundle register with async active-low reset, hold enable and bubble-load,
//   instantiated three times.
// - The sequencer FSM stays inline.
// TESTING
// 1. Reset: rst_i=0 mid-stream -> all outputs 0 immediately; after release, lw in ID -> mem_read_ex_o=1 after 1 edge,
//    mem_read_mem_o after 2, mem_to_reg_wb_o after 3.
// 2. Decode sweep: R, I, lw, sw, beq each pushed once -> alu_op_ex_o = 10, 11, 00, 00, 01 respectively;
//    alu_src_ex_o = 0, 1, 1, 1, 0.
// 3. MC_LAT=4, MUL (op=0110011, funct7=0000001) reaches EX -> mc_stall_o=1 for 3 cycles; mc_done_o=1 on the 4th;
//    EX/MEM carries bubbles for 3 cycles, then reg_write_mem_o=1.
// 4. mem_stall_i=1 for 5 cycles during BUSY at cnt=2 -> all outputs frozen; afterwards 1 stall cycle remains,
//    then mc_done_o=1.
// 5. flush_i=1 with sw in ID -> mem_write_mem_o stays 0 two edges later; flush_i=1 concurrent with mem_stall_i=1
//    -> no squash until the stall drops.
// 6. CTRL_ILLEGAL_TRAP_EN defined, op_i=7'b1111111 -> illegal_o=1 and a bubble enters EX;
//    macro not defined -> illegal_o=0 and the bundle is all zero.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the RV32 main-control pipeline: opcodes, ALUOp codes,
// the control bundle carried through ID/EX, EX/MEM and MEM/WB, and the sequencer state type.
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       is_mc;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control-bundle register: async active-low reset to bubble, hold has
// priority over bubble-load, otherwise the incoming bundle is captured.
module ctrl_stage_reg
  import ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  ctrl_bundle_t d_i,
  output ctrl_bundle_t q_o
);

  ctrl_bundle_t r_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_q <= CTRL_BUBBLE;
    end else if (!hold_i) begin
      r_q <= bubble_i ? CTRL_BUBBLE : d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/ctrl_pipe_seq.sv
// Main control for the 5-stage RV32 core with a multi-cycle EX sequencer for MUL-class ops.
// Optional macro CTRL_ILLEGAL_TRAP_EN enables the combinational illegal-opcode flag in ID.
module ctrl_pipe_seq
  import ctrl_pkg::*;
#(
  parameter  int OP_W    = 7,
  parameter  int ALUOP_W = 2,
  parameter  int MC_LAT  = 4,
  localparam int CNT_W   = $clog2(MC_LAT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [6:0]         funct7_i,
  input  logic               noop_i,
  input  logic               flush_i,
  input  logic               mem_stall_i,
  output logic [ALUOP_W-1:0] alu_op_ex_o,
  output logic               alu_src_ex_o,
  output logic               branch_ex_o,
  output logic               mem_read_ex_o,
  output logic               mem_read_mem_o,
  output logic               mem_write_mem_o,
  output logic               reg_write_mem_o,
  output logic               reg_write_wb_o,
  output logic               mem_to_reg_wb_o,
  output logic               mc_stall_o,
  output logic               mc_done_o,
  output logic               illegal_o,
  output seq_state_t         dbg_state_o
);

  ctrl_bundle_t     w_dec;
  ctrl_bundle_t     w_idex;
  ctrl_bundle_t     w_exmem;
  ctrl_bundle_t     w_memwb;
  logic             w_known;
  logic             w_mul_ex;
  logic             w_last;
  logic             w_mc_stall;
  logic             w_mc_done;
  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_dec   = CTRL_BUBBLE;
    w_known = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = ALUOP_R;
        w_dec.is_mc     = (funct7_i == MULDIV_FUNCT7);
      end
      OP_ITYPE: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALUOP_I;
      end
      OP_LW: begin
        w_dec.reg_write  = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.alu_op     = ALUOP_MEM;
      end
      OP_SW: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALUOP_MEM;
      end
      OP_BEQ: begin
        w_dec.branch = 1'b1;
        w_dec.alu_op = ALUOP_BEQ;
      end
      default: w_known = 1'b0;
    endcase
    if (noop_i || !w_known) begin
      w_dec = CTRL_BUBBLE;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = rst_i & ~noop_i & ~w_known;
`else
  assign illegal_o = 1'b0;
`endif

  // Stall contract: mem_stall freezes every stage; mc_stall holds only ID/EX and
  // feeds bubbles downstream so MEM/WB keeps draining older instructions.
  ctrl_stage_reg u_idex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (mem_stall_i | w_mc_stall),
    .bubble_i (flush_i),
    .d_i      (w_dec),
    .q_o      (w_idex)
  );

  ctrl_stage_reg u_exmem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (mem_stall_i),
    .bubble_i (w_mc_stall),
    .d_i      (w_idex),
    .q_o      (w_exmem)
  );

  ctrl_stage_reg u_memwb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (mem_stall_i),
    .bubble_i (1'b0),
    .d_i      (w_exmem),
    .q_o      (w_memwb)
  );

  assign w_mul_ex = w_idex.is_mc && (w_idex.alu_op == ALUOP_R);
  assign w_last   = (r_cnt == CNT_W'(MC_LAT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!mem_stall_i) begin
      case (r_state)
        SEQ_IDLE: begin
          if (w_mul_ex && (MC_LAT > 1)) begin
            w_state_nxt = SEQ_BUSY;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        SEQ_BUSY: begin
          if (w_last) begin
            w_state_nxt = SEQ_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = SEQ_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The stall is Mealy on the ID/EX bundle so the first EX cycle of a MUL already stalls.
  always_comb begin
    w_mc_stall = 1'b0;
    w_mc_done  = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (w_mul_ex) begin
          if (MC_LAT > 1) w_mc_stall = 1'b1;
          else            w_mc_done  = ~mem_stall_i;
        end
      end
      SEQ_BUSY: begin
        w_mc_stall = ~w_last;
        w_mc_done  = w_last & ~mem_stall_i;
      end
      default: begin
        w_mc_stall = 1'b0;
        w_mc_done  = 1'b0;
      end
    endcase
  end

  assign alu_op_ex_o     = ALUOP_W'(w_idex.alu_op);
  assign alu_src_ex_o    = w_idex.alu_src;
  assign branch_ex_o     = w_idex.branch;
  assign mem_read_ex_o   = w_idex.mem_read;
  assign mem_read_mem_o  = w_exmem.mem_read;
  assign mem_write_mem_o = w_exmem.mem_write;
  assign reg_write_mem_o = w_exmem.reg_write;
  assign reg_write_wb_o  = w_memwb.reg_write;
  assign mem_to_reg_wb_o = w_memwb.mem_to_reg;
  assign mc_stall_o      = w_mc_stall;
  assign mc_done_o       = w_mc_done;
  assign dbg_state_o     = r_state;

  logic w_unused;
  assign w_unused = ^{w_memwb.mem_read, w_memwb.mem_write, w_memwb.alu_src,
                      w_memwb.branch, w_memwb.alu_op, w_memwb.is_mc, w_known};

endmodule

// File: tb/tb_ctrl_pipe_seq.sv
// Bench for ctrl_pipe_seq: decode vector table fed through a per-stage scoreboard,
// plus hand sequences for reset, multi-cycle ops, memory stalls and flushes.
module tb_ctrl_pipe_seq;
  import ctrl_pkg::*;

  localparam int MC_LAT = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] op_i;
  logic [6:0] funct7_i;
  logic       noop_i;
  logic       flush_i;
  logic       mem_stall_i;
  logic [1:0] alu_op_ex_o;
  logic       alu_src_ex_o, branch_ex_o, mem_read_ex_o, mem_read_mem_o, mem_write_mem_o;
  logic       reg_write_mem_o, reg_write_wb_o, mem_to_reg_wb_o, mc_stall_o, mc_done_o, illegal_o;
  seq_state_t dbg_state_o;

  ctrl_pipe_seq #(.OP_W(7), .ALUOP_W(2), .MC_LAT(MC_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct7_i(funct7_i), .noop_i(noop_i),
    .flush_i(flush_i), .mem_stall_i(mem_stall_i), .alu_op_ex_o(alu_op_ex_o),
    .alu_src_ex_o(alu_src_ex_o), .branch_ex_o(branch_ex_o), .mem_read_ex_o(mem_read_ex_o),
    .mem_read_mem_o(mem_read_mem_o), .mem_write_mem_o(mem_write_mem_o),
    .reg_write_mem_o(reg_write_mem_o), .reg_write_wb_o(reg_write_wb_o),
    .mem_to_reg_wb_o(mem_to_reg_wb_o), .mc_stall_o(mc_stall_o), .mc_done_o(mc_done_o),
    .illegal_o(illegal_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct {
    logic [6:0] op;
    logic [6:0] f7;
    logic       noop;
    logic [1:0] alu;
    logic       src;
    logic       br;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic       m2r;
    logic       ill;
  } vec_t;

  vec_t vecs[10];

  // Scoreboard queues: EX {alu_op, alu_src, branch, mem_read}, MEM {mem_read, mem_write, reg_write}, WB {reg_write, mem_to_reg}
  logic [4:0] exp_q[$];
  logic [2:0] exp_mem_q[$];
  logic [1:0] exp_wb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [6:0] f7, input logic noop,
                        input logic flush, input logic mstall);
    op_i = op; funct7_i = f7; noop_i = noop; flush_i = flush; mem_stall_i = mstall;
  endtask

  task automatic idle(input int n);
    set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {18'd0, alu_op_ex_o, alu_src_ex_o, branch_ex_o, mem_read_ex_o, mem_read_mem_o,
            mem_write_mem_o, reg_write_mem_o, reg_write_wb_o, mem_to_reg_wb_o,
            mc_stall_o, mc_done_o, illegal_o, 1'b0};
  endfunction

  task automatic sb_pop(input string tag);
    logic [4:0] e_ex;
    logic [2:0] e_mem;
    logic [1:0] e_wb;
    e_ex  = exp_q.pop_front();
    e_mem = exp_mem_q.pop_front();
    e_wb  = exp_wb_q.pop_front();
    chk({tag, "_ex"},  {alu_op_ex_o, alu_src_ex_o, branch_ex_o, mem_read_ex_o}, e_ex);
    chk({tag, "_mem"}, {mem_read_mem_o, mem_write_mem_o, reg_write_mem_o}, e_mem);
    chk({tag, "_wb"},  {reg_write_wb_o, mem_to_reg_wb_o}, e_wb);
  endtask

  task automatic mul_pattern(input string tag, input int n, input logic b2b);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_stall%0d", tag, k), mc_stall_o, ((k % 4) != 3));
      chk($sformatf("%s_done%0d", tag, k), mc_done_o, ((k % 4) == 3));
      chk($sformatf("%s_rwmem%0d", tag, k), reg_write_mem_o, (b2b && k == 4));
      if (k == 4) set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{OP_RTYPE, 7'b0000000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{OP_ITYPE, 7'b0000000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{OP_LW,    7'b0000000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{OP_SW,    7'b0000000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{OP_BEQ,   7'b0000000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_RTYPE, 7'b0100000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{7'b1111111, 7'b0000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TRAP};
    vecs[7] = '{OP_LW,    7'b0000000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{7'b1111111, 7'b0000000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{7'b0110111, 7'b0000001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TRAP};

    // Reset at start of time
    rst_i = 1'b0;
    set_in(OP_LW, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_outs", all_outs(), 32'd0);
    chk("reset_state", dbg_state_o, SEQ_IDLE);
    rst_i = 1'b1;
    idle(3);

    // Decode table through the stage scoreboard
    exp_mem_q.push_back(3'd0);
    exp_wb_q.push_back(2'd0);
    exp_wb_q.push_back(2'd0);
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].op, vecs[i].f7, vecs[i].noop, 1'b0, 1'b0);
      #1;
      chk($sformatf("illegal_v%0d", i), illegal_o, vecs[i].ill);
      exp_q.push_back({vecs[i].alu, vecs[i].src, vecs[i].br, vecs[i].mrd});
      exp_mem_q.push_back({vecs[i].mrd, vecs[i].mwr, vecs[i].rw});
      exp_wb_q.push_back({vecs[i].rw, vecs[i].m2r});
      tick();
      sb_pop($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(5'd0);
      exp_mem_q.push_back(3'd0);
      exp_wb_q.push_back(2'd0);
      tick();
      sb_pop($sformatf("drain%0d", i));
    end
    exp_q.delete();
    exp_mem_q.delete();
    exp_wb_q.delete();

    // Reset mid-stream, then lw latency through the stages
    set_in(OP_LW, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("pre_rst_m2r_wb", mem_to_reg_wb_o, 1'b1);
    #2 rst_i = 1'b0;
    #1 chk("async_rst_outs", all_outs(), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    chk("lw_rd_ex", mem_read_ex_o, 1'b1);
    chk("lw_rd_mem_early", mem_read_mem_o, 1'b0);
    set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lw_rd_mem", mem_read_mem_o, 1'b1);
    chk("lw_m2r_wb_early", mem_to_reg_wb_o, 1'b0);
    tick();
    chk("lw_m2r_wb", mem_to_reg_wb_o, 1'b1);
    idle(3);

    // Single MUL: 3 stall cycles then done
    set_in(OP_RTYPE, MULDIV_FUNCT7, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(OP_LW, 7'd0, 1'b0, 1'b1, 1'b0);
    chk("mul_alu_ex", alu_op_ex_o, ALUOP_R);
    mul_pattern("mul", 4, 1'b0);
    chk("mul_rw_mem", reg_write_mem_o, 1'b1);
    chk("mul_after_stall", mc_stall_o, 1'b0);
    chk("mul_after_state", dbg_state_o, SEQ_IDLE);
    idle(3);

    // MUL with a 5-cycle memory stall at cnt=2
    set_in(OP_RTYPE, MULDIV_FUNCT7, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("ms_pre_state", dbg_state_o, SEQ_BUSY);
    mem_stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("ms_frz%0d", k), {mc_stall_o, mc_done_o, alu_op_ex_o, reg_write_mem_o}, 5'b10100);
    end
    mem_stall_i = 1'b0;
    #1 chk("ms_last_stall", {mc_stall_o, mc_done_o}, 2'b10);
    tick();
    chk("ms_done", {mc_stall_o, mc_done_o}, 2'b01);
    mem_stall_i = 1'b1;
    #1 chk("ms_done_suppr", {mc_stall_o, mc_done_o}, 2'b00);
    tick();
    chk("ms_hold_rwmem", reg_write_mem_o, 1'b0);
    mem_stall_i = 1'b0;
    #1 chk("ms_done_again", mc_done_o, 1'b1);
    tick();
    chk("ms_rw_mem", reg_write_mem_o, 1'b1);
    idle(3);

    // Back-to-back MULs
    set_in(OP_RTYPE, MULDIV_FUNCT7, 1'b0, 1'b0, 1'b0);
    tick();
    mul_pattern("b2b", 8, 1'b1);
    chk("b2b_rw_mem", reg_write_mem_o, 1'b1);
    idle(3);

    // Flush squashes sw; unflushed sw reaches MEM
    set_in(OP_SW, 7'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("fl_src_ex", alu_src_ex_o, 1'b0);
    set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_mwr_mem", mem_write_mem_o, 1'b0);
    set_in(OP_SW, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("nofl_mwr_mem", mem_write_mem_o, 1'b1);
    idle(2);

    // Flush during memory stall waits for the stall to drop
    set_in(OP_LW, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(OP_SW, 7'd0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("flms_hold%0d", k), {mem_read_ex_o, mem_read_mem_o}, 2'b10);
    end
    mem_stall_i = 1'b0;
    tick();
    chk("flms_squash", {mem_read_ex_o, alu_src_ex_o, mem_read_mem_o}, 3'b001);
    set_in(7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flms_mwr_mem", mem_write_mem_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
